seq_alu: RTL and testbench

Parametrised, registered ALU with a start/done handshake. It executes single-cycle arithmetic, logic and shift operations, plus an optional iterative multiply. It generalises the combinational ALU: registered NZCV flags, shifts, a multi-cycle operation and back-pressure. It sits between the datapath register read stage and writeback, and the control unit sequences it through `ready_o` and `done_o`.

---
 rtl/seq_alu.sv | 167 ++++++++++++++++
 tb/tb_seq_alu.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_alu.sv
// seq_alu: registered ALU with start/done handshake and registered NZCV flags.
// Define SEQ_ALU_MUL_EN to add the N-cycle shift-add multiplier (opcode 1000).
module seq_alu #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start_i,
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic [3:0]   alucontrol,
  output logic         ready_o,
  output logic         done_o,
  output logic [N-1:0] result,
  output logic [3:0]   output_flags,
  output logic         err_o
);
  localparam int SW = $clog2(N);
  localparam logic [3:0] OP_ADD = 4'b0000, OP_SUB = 4'b0001, OP_AND = 4'b0010,
                         OP_OR  = 4'b0011, OP_XOR = 4'b0100, OP_SLL = 4'b0101,
                         OP_SRL = 4'b0110, OP_SRA = 4'b0111;

  logic [N-1:0]      res_q, res_d;
  logic [3:0]        flg_q, flg_d;
  logic              done_q, done_d, err_q, err_d;
  logic              accept;
  logic [SW-1:0]     sh;
  logic [N:0]        add_x, sll_x, srl_x;
  logic signed [N:0] sra_x;
  logic [N-1:0]      sub_x, alu_res;
  logic              alu_c, alu_v, alu_ok;

  assign accept = start_i && ready_o;
  assign sh     = b_i[SW-1:0];

  // Shifts run one bit wider so the last bit shifted out lands in the spare bit.
  always_comb begin
    add_x   = {1'b0, a_i} + {1'b0, b_i};
    sub_x   = a_i - b_i;
    sll_x   = {1'b0, a_i} << sh;
    srl_x   = {a_i, 1'b0} >> sh;
    sra_x   = $signed({a_i, 1'b0}) >>> sh;
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_ok  = 1'b1;
    case (alucontrol)
      OP_ADD: begin
        alu_res = add_x[N-1:0];
        alu_c   = add_x[N];
        alu_v   = (a_i[N-1] == b_i[N-1]) && (add_x[N-1] != a_i[N-1]);
      end
      OP_SUB: begin
        alu_res = sub_x;
        alu_c   = a_i < b_i;
        alu_v   = (a_i[N-1] != b_i[N-1]) && (sub_x[N-1] != a_i[N-1]);
      end
      OP_AND: alu_res = a_i & b_i;
      OP_OR:  alu_res = a_i | b_i;
      OP_XOR: alu_res = a_i ^ b_i;
      OP_SLL: begin
        alu_res = sll_x[N-1:0];
        alu_c   = sll_x[N];
      end
      OP_SRL: begin
        alu_res = srl_x[N:1];
        alu_c   = srl_x[0];
      end
      OP_SRA: begin
        alu_res = sra_x[N:1];
        alu_c   = sra_x[0];
      end
      default: alu_ok = 1'b0;
    endcase
  end

`ifdef SEQ_ALU_MUL_EN
  localparam logic [3:0] OP_MUL = 4'b1000;
  localparam logic [0:0] S_IDLE = 1'b0, S_BUSY = 1'b1;

  logic [0:0]     state_q, state_d;
  logic [SW-1:0]  cnt_q, cnt_d;
  logic [N-1:0]   mcand_q, mcand_d;
  logic [2*N-1:0] prod_q, prod_d, prod_step;
  logic [N:0]     hi_sum;

  // Low half starts as the multiplier and is consumed LSB-first as the product shifts in.
  always_comb begin
    hi_sum    = {1'b0, prod_q[2*N-1:N]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
    prod_step = {hi_sum, prod_q[N-1:1]};
  end

  assign ready_o = !rst && (state_q == S_IDLE);
`else
  assign ready_o = !rst;
`endif

  always_comb begin
    res_d  = res_q;
    flg_d  = flg_q;
    done_d = 1'b0;
    err_d  = 1'b0;
`ifdef SEQ_ALU_MUL_EN
    state_d = state_q;
    cnt_d   = cnt_q;
    mcand_d = mcand_q;
    prod_d  = prod_q;
    if (state_q == S_BUSY) begin
      prod_d = prod_step;
      cnt_d  = cnt_q - 1'b1;
      if (cnt_q == '0) begin
        res_d   = prod_step[N-1:0];
        flg_d   = {prod_step[N-1], prod_step[N-1:0] == '0, 1'b0, |prod_step[2*N-1:N]};
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
    end else if (accept && alucontrol == OP_MUL) begin
      state_d = S_BUSY;
      cnt_d   = SW'(N - 1);
      mcand_d = a_i;
      prod_d  = {{N{1'b0}}, b_i};
    end else
`endif
    if (accept) begin
      done_d = 1'b1;
      if (alu_ok) begin
        res_d = alu_res;
        flg_d = {alu_res[N-1], alu_res == '0, alu_c, alu_v};
      end else begin
        res_d = '0;
        flg_d = '0;
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      res_q   <= '0;
      flg_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef SEQ_ALU_MUL_EN
      state_q <= S_IDLE;
      cnt_q   <= '0;
      mcand_q <= '0;
      prod_q  <= '0;
`endif
    end else begin
      res_q   <= res_d;
      flg_q   <= flg_d;
      done_q  <= done_d;
      err_q   <= err_d;
`ifdef SEQ_ALU_MUL_EN
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mcand_q <= mcand_d;
      prod_q  <= prod_d;
`endif
    end
  end

  assign result       = res_q;
  assign output_flags = flg_q;
  assign done_o       = done_q;
  assign err_o        = err_q;
endmodule

// File: tb/tb_seq_alu.sv
// Bench for seq_alu: behavioural reference model checked every cycle, plus directed literal cases.
module tb_seq_alu;
  localparam int N = 32;
`ifdef SEQ_ALU_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start_i = 1'b0;
  logic [N-1:0] a_i = '0, b_i = '0;
  logic [3:0]   alucontrol = '0;
  logic         ready_o, done_o, err_o;
  logic [N-1:0] result;
  logic [3:0]   output_flags;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  seq_alu #(.N(N)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .a_i(a_i), .b_i(b_i),
    .alucontrol(alucontrol), .ready_o(ready_o), .done_o(done_o),
    .result(result), .output_flags(output_flags), .err_o(err_o)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference semantics straight from the opcode table, using wide integer arithmetic.
  function automatic void ref_op(input logic [3:0] op, input logic [N-1:0] a, input logic [N-1:0] b,
                                 output logic [N-1:0] r, output logic [3:0] f, output logic e);
    longint sa, sb, sr;
    logic [63:0] p;
    int sh;
    logic c, v;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    sh = int'(b[4:0]);
    r = '0; c = 1'b0; v = 1'b0; e = 1'b0;
    case (op)
      4'd0: begin
        p = {32'd0, a} + {32'd0, b};
        r = p[31:0]; c = p[32];
        sr = sa + sb; v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      end
      4'd1: begin
        r = a - b; c = (a < b);
        sr = sa - sb; v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: begin r = a << sh; c = (sh == 0) ? 1'b0 : a[N-sh]; end
      4'd6: begin r = a >> sh; c = (sh == 0) ? 1'b0 : a[sh-1]; end
      4'd7: begin r = $signed(a) >>> sh; c = (sh == 0) ? 1'b0 : a[sh-1]; end
      4'd8: begin
        if (MUL_EN) begin
          p = {32'd0, a} * {32'd0, b};
          r = p[31:0]; v = (p[63:32] != 0);
        end else e = 1'b1;
      end
      default: e = 1'b1;
    endcase
    f = e ? 4'b0000 : {r[N-1], r == 0, c, v};
  endfunction

  logic [N-1:0] m_res, m_pres;
  logic [3:0]   m_flg, m_pflg;
  logic         m_done, m_err;
  int           m_busy;

  always @(posedge clk) begin
    logic [N-1:0] r;
    logic [3:0] f;
    logic e;
    if (rst) begin
      m_res = '0; m_flg = '0; m_done = 1'b0; m_err = 1'b0; m_busy = 0;
    end else begin
      m_done = 1'b0; m_err = 1'b0;
      if (m_busy > 0) begin
        m_busy--;
        if (m_busy == 0) begin m_res = m_pres; m_flg = m_pflg; m_done = 1'b1; end
      end else if (start_i) begin
        ref_op(alucontrol, a_i, b_i, r, f, e);
        if (MUL_EN && alucontrol == 4'd8) begin
          m_busy = N; m_pres = r; m_pflg = f;
        end else begin
          m_res = r; m_flg = f; m_err = e; m_done = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("result", result, m_res);
      cmp("flags", {28'd0, output_flags}, {28'd0, m_flg});
      cmp("done", {31'd0, done_o}, {31'd0, m_done});
      cmp("err", {31'd0, err_o}, {31'd0, m_err});
      cmp("ready", {31'd0, ready_o}, {31'd0, !rst && m_busy == 0});
    end
  end

  task automatic step(input logic s, input logic [3:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
    start_i = s; alucontrol = op; a_i = a; b_i = b;
    @(posedge clk); #1;
  endtask

  function automatic logic [N-1:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rst = 1'b1;
    repeat (3) step(1'b0, 4'd0, '0, '0);
    chk_en = 1'b1;
    cmp("lit_rst_ready", {31'd0, ready_o}, 32'd0);
    cmp("lit_rst_result", result, 32'd0);
    cmp("lit_rst_done", {31'd0, done_o}, 32'd0);

    rst = 1'b0;
    step(1'b0, 4'd0, '0, '0);
    cmp("lit_ready_after_rst", {31'd0, ready_o}, 32'd1);

    step(1'b1, 4'd0, 32'h7FFF_FFFF, 32'h1);
    cmp("lit_add_res", result, 32'h8000_0000);
    cmp("lit_add_flags", {28'd0, output_flags}, 32'h9);
    cmp("lit_add_done", {31'd0, done_o}, 32'd1);

    step(1'b1, 4'd1, 32'd15, 32'd1);
    cmp("lit_sub1_res", result, 32'd14);
    cmp("lit_sub1_flags", {28'd0, output_flags}, 32'h0);
    cmp("lit_sub1_ready", {31'd0, ready_o}, 32'd1);
    step(1'b1, 4'd1, 32'd1, 32'd2);
    cmp("lit_sub2_res", result, 32'hFFFF_FFFF);
    cmp("lit_sub2_flags", {28'd0, output_flags}, 32'hA);
    cmp("lit_sub2_done", {31'd0, done_o}, 32'd1);

    step(1'b1, 4'd7, 32'h8000_0000, 32'd4);
    cmp("lit_sra_res", result, 32'hF800_0000);
    cmp("lit_sra_flags", {28'd0, output_flags}, 32'h8);

    step(1'b1, 4'd5, 32'hC000_0000, 32'd1);
    cmp("lit_sll_res", result, 32'h8000_0000);
    cmp("lit_sll_flags", {28'd0, output_flags}, 32'hA);

    step(1'b1, 4'hF, 32'h1234_5678, 32'h9ABC_DEF0);
    cmp("lit_bad_res", result, 32'd0);
    cmp("lit_bad_flags", {28'd0, output_flags}, 32'h0);
    cmp("lit_bad_err", {31'd0, err_o}, 32'd1);
    cmp("lit_bad_done", {31'd0, done_o}, 32'd1);
    step(1'b0, 4'd0, '0, '0);
    cmp("lit_done_pulse", {31'd0, done_o}, 32'd0);

`ifdef SEQ_ALU_MUL_EN
    step(1'b1, 4'd8, 32'h0001_0000, 32'h0001_0000);
    cmp("lit_mul_ready_low", {31'd0, ready_o}, 32'd0);
    for (int i = 1; i < N; i++) begin
      step(1'b1, 4'($urandom_range(0, 8)), $urandom, $urandom);
      cmp("lit_mul_busy_ready", {31'd0, ready_o}, 32'd0);
      cmp("lit_mul_busy_done", {31'd0, done_o}, 32'd0);
    end
    step(1'b0, 4'd0, '0, '0);
    cmp("lit_mul1_done", {31'd0, done_o}, 32'd1);
    cmp("lit_mul1_res", result, 32'd0);
    cmp("lit_mul1_flags", {28'd0, output_flags}, 32'h5);
    cmp("lit_mul1_ready", {31'd0, ready_o}, 32'd1);

    step(1'b1, 4'd8, 32'd7, 32'd6);
    repeat (N - 1) step(1'b0, 4'd0, '0, '0);
    step(1'b0, 4'd0, '0, '0);
    cmp("lit_mul2_done", {31'd0, done_o}, 32'd1);
    cmp("lit_mul2_res", result, 32'd42);
    cmp("lit_mul2_flags", {28'd0, output_flags}, 32'h0);

    step(1'b1, 4'd8, 32'hDEAD_BEEF, 32'h0000_0003);
    repeat (10) step(1'b0, 4'd0, '0, '0);
    rst = 1'b1;
    step(1'b0, 4'd0, '0, '0);
    cmp("lit_abort_done", {31'd0, done_o}, 32'd0);
    cmp("lit_abort_res", result, 32'd0);
    rst = 1'b0;
    step(1'b0, 4'd0, '0, '0);
    cmp("lit_abort_ready", {31'd0, ready_o}, 32'd1);
    cmp("lit_abort_nodone", {31'd0, done_o}, 32'd0);
`else
    step(1'b1, 4'd8, 32'd7, 32'd6);
    cmp("lit_nomul_res", result, 32'd0);
    cmp("lit_nomul_err", {31'd0, err_o}, 32'd1);
    cmp("lit_nomul_done", {31'd0, done_o}, 32'd1);
    cmp("lit_nomul_ready", {31'd0, ready_o}, 32'd1);
    rst = 1'b1;
    step(1'b0, 4'd0, '0, '0);
    cmp("lit_rst2_res", result, 32'd0);
    rst = 1'b0;
    step(1'b0, 4'd0, '0, '0);
    cmp("lit_rst2_ready", {31'd0, ready_o}, 32'd1);
`endif

    for (int i = 0; i < 1500; i++) begin
      logic [3:0] op;
      op  = ($urandom_range(0, 9) == 9) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
      rst = ($urandom_range(0, 199) == 0);
      step($urandom_range(0, 3) != 0, op, pick(), pick());
    end
    rst = 1'b0;
    step(1'b0, 4'd0, '0, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
